// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, tracks the one-cycle BRAM read
// latency, and buffers returned instructions in a 2-entry queue to decode.
module fetch_ctrl #(
  parameter int                 ADDR_W   = 8,
  parameter logic [ADDR_W-1:0]  RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] bram_addr,
  input  logic [31:0]       bram_inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] out_pc,
  output logic              out_is_jump,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              stalled
);

  localparam logic [6:0] JALR_OP = 7'b1100111;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_JWAIT = 1'b1
  } state_t;

  function automatic logic is_jalr(input logic [31:0] inst);
    return (inst[6:0] == JALR_OP);
  endfunction

  state_t            state_r;
  state_t            state_nxt_s;

  logic [ADDR_W-1:0] pc_r;
  logic              inflight_r;
  logic [ADDR_W-1:0] inflight_pc_r;

  // Queue is a two-slot shift structure: head slot always feeds decode.
  logic [31:0]       head_inst_r;
  logic [ADDR_W-1:0] head_pc_r;
  logic [31:0]       tail_inst_r;
  logic [ADDR_W-1:0] tail_pc_r;
  logic [1:0]        occ_r;

  logic              fire_s;
  logic [1:0]        count_s;
  logic              ret_jump_s;
  logic              push_s;
  logic              issue_s;
  logic              stalled_s;

  // Handshake and occupancy terms shared by the FSM and datapath.
  always_comb begin
    fire_s     = (occ_r != 2'd0) & out_ready;
    count_s    = occ_r + {1'b0, inflight_r};
    ret_jump_s = inflight_r & is_jalr(bram_inst);
    push_s     = inflight_r & ~redirect_valid;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic; a redirect always wins over a returning JALR.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (redirect_valid) begin
          state_nxt_s = ST_RUN;
        end else if (ret_jump_s) begin
          state_nxt_s = ST_JWAIT;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_JWAIT: begin
        if (redirect_valid) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_JWAIT;
        end
      end
      default: begin
        state_nxt_s = ST_RUN;
      end
    endcase
  end

  // FSM outputs: issue only in RUN with room for the returning word.
  always_comb begin
    issue_s   = 1'b0;
    stalled_s = 1'b0;
    case (state_r)
      ST_RUN: begin
        issue_s   = ~ret_jump_s & ~redirect_valid & ((count_s < 2'd2) | fire_s);
        stalled_s = 1'b0;
      end
      ST_JWAIT: begin
        issue_s   = 1'b0;
        stalled_s = 1'b1;
      end
      default: begin
        issue_s   = 1'b0;
        stalled_s = 1'b0;
      end
    endcase
  end

  // Program counter and in-flight read tracking.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_r          <= RESET_PC;
      inflight_r    <= 1'b0;
      inflight_pc_r <= RESET_PC;
    end else if (redirect_valid) begin
      pc_r          <= redirect_pc;
      inflight_r    <= 1'b0;
      inflight_pc_r <= inflight_pc_r;
    end else if (issue_s) begin
      pc_r          <= pc_r + {{(ADDR_W-1){1'b0}}, 1'b1};
      inflight_r    <= 1'b1;
      inflight_pc_r <= pc_r;
    end else begin
      pc_r          <= pc_r;
      inflight_r    <= 1'b0;
      inflight_pc_r <= inflight_pc_r;
    end
  end

  // Two-entry instruction queue; a redirect flushes it and drops any push.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ_r       <= 2'd0;
      head_inst_r <= 32'd0;
      head_pc_r   <= {ADDR_W{1'b0}};
      tail_inst_r <= 32'd0;
      tail_pc_r   <= {ADDR_W{1'b0}};
    end else if (redirect_valid) begin
      occ_r <= 2'd0;
    end else begin
      case ({push_s, fire_s})
        2'b10: begin
          if (occ_r == 2'd0) begin
            head_inst_r <= bram_inst;
            head_pc_r   <= inflight_pc_r;
          end else begin
            tail_inst_r <= bram_inst;
            tail_pc_r   <= inflight_pc_r;
          end
          occ_r <= occ_r + 2'd1;
        end
        2'b01: begin
          head_inst_r <= tail_inst_r;
          head_pc_r   <= tail_pc_r;
          occ_r       <= occ_r - 2'd1;
        end
        2'b11: begin
          if (occ_r == 2'd1) begin
            head_inst_r <= bram_inst;
            head_pc_r   <= inflight_pc_r;
          end else begin
            head_inst_r <= tail_inst_r;
            head_pc_r   <= tail_pc_r;
            tail_inst_r <= bram_inst;
            tail_pc_r   <= inflight_pc_r;
          end
        end
        default: begin
          occ_r <= occ_r;
        end
      endcase
    end
  end

  assign bram_addr   = pc_r;
  assign out_valid   = (occ_r != 2'd0);
  assign out_inst    = head_inst_r;
  assign out_pc      = head_pc_r;
  assign out_is_jump = is_jalr(head_inst_r);
  assign stalled     = stalled_s;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: streaming, backpressure, JALR stall,
// redirects, PC wrap and reset while stalled.
module tb_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic [7:0]  bram_addr;
  logic [31:0] bram_inst;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [7:0]  out_pc;
  logic        out_is_jump;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        stalled;

  logic [31:0] mem [256];
  int checks = 0;
  int errors = 0;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] JALR = 32'h0000_8067;

  fetch_ctrl #(.ADDR_W(8), .RESET_PC(8'h00)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bram_addr      (bram_addr),
    .bram_inst      (bram_inst),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .out_is_jump    (out_is_jump),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stalled        (stalled)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-read BRAM model.
  always @(posedge clk) bram_inst <= mem[bram_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cyc(input string tag, input logic v, input logic [7:0] pc,
                         input logic [7:0] addr, input logic st);
    chk({tag, "_valid"}, 32'(out_valid), 32'(v));
    if (v) chk({tag, "_pc"}, 32'(out_pc), 32'(pc));
    chk({tag, "_addr"}, 32'(bram_addr), 32'(addr));
    chk({tag, "_stalled"}, 32'(stalled), 32'(st));
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    rst_n          = 1'b0;
    out_ready      = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = NOP;

    // Test 1: reset 3 cycles, stream NOPs.
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk_cyc("rst_t0", 1'b0, 8'h00, 8'h00, 1'b0);
    step();
    chk_cyc("t1", 1'b0, 8'h00, 8'h01, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk_cyc("stream", 1'b1, 8'(k), 8'(k + 2), 1'b0);
    end
    chk("stream_inst", out_inst, NOP);
    chk("stream_jump", 32'(out_is_jump), 32'd0);

    // Test 2: backpressure for 6 cycles, then release.
    out_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      chk_cyc("hold", 1'b1, 8'h03, 8'h05, 1'b0);
    end
    out_ready = 1'b1;
    for (int k = 4; k < 7; k++) begin
      step();
      chk_cyc("release", 1'b1, 8'(k), 8'(k + 2), 1'b0);
    end

    // Test 4: fill queue, redirect to 0x20.
    out_ready = 1'b0;
    step();
    chk_cyc("fill", 1'b1, 8'h06, 8'h08, 1'b0);
    redirect_valid = 1'b1;
    redirect_pc    = 8'h20;
    step();
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    chk_cyc("redir20_t1", 1'b0, 8'h00, 8'h20, 1'b0);
    step();
    chk_cyc("redir20_t2", 1'b0, 8'h00, 8'h21, 1'b0);
    step();
    chk_cyc("redir20_t3", 1'b1, 8'h20, 8'h22, 1'b0);
    step();
    chk_cyc("redir20_t4", 1'b1, 8'h21, 8'h23, 1'b0);

    // Test 5: redirect to 0xFE while streaming with a read in flight; wrap.
    redirect_valid = 1'b1;
    redirect_pc    = 8'hFE;
    step();
    redirect_valid = 1'b0;
    chk_cyc("redirFE_t1", 1'b0, 8'h00, 8'hFE, 1'b0);
    step();
    chk_cyc("redirFE_t2", 1'b0, 8'h00, 8'hFF, 1'b0);
    step();
    chk_cyc("wrap0", 1'b1, 8'hFE, 8'h00, 1'b0);
    step();
    chk_cyc("wrap1", 1'b1, 8'hFF, 8'h01, 1'b0);
    step();
    chk_cyc("wrap2", 1'b1, 8'h00, 8'h02, 1'b0);
    step();
    chk_cyc("wrap3", 1'b1, 8'h01, 8'h03, 1'b0);

    // Test 3: JALR at address 3 stalls until redirect to 0x40.
    mem[3] = JALR;
    rst_n  = 1'b0;
    step();
    rst_n = 1'b1;
    chk_cyc("j_rst", 1'b0, 8'h00, 8'h00, 1'b0);
    step();
    chk_cyc("j_t1", 1'b0, 8'h00, 8'h01, 1'b0);
    step();
    chk_cyc("j_t2", 1'b1, 8'h00, 8'h02, 1'b0);
    chk("j_t2_jump", 32'(out_is_jump), 32'd0);
    step();
    chk_cyc("j_t3", 1'b1, 8'h01, 8'h03, 1'b0);
    step();
    chk_cyc("j_t4", 1'b1, 8'h02, 8'h04, 1'b0);
    step();
    chk_cyc("j_t5", 1'b1, 8'h03, 8'h04, 1'b1);
    chk("j_t5_jump", 32'(out_is_jump), 32'd1);
    chk("j_t5_inst", out_inst, JALR);
    step();
    chk_cyc("j_t6", 1'b0, 8'h00, 8'h04, 1'b1);
    step();
    chk_cyc("j_t7", 1'b0, 8'h00, 8'h04, 1'b1);
    redirect_valid = 1'b1;
    redirect_pc    = 8'h40;
    step();
    redirect_valid = 1'b0;
    chk_cyc("j_redir_t1", 1'b0, 8'h00, 8'h40, 1'b0);
    step();
    chk_cyc("j_redir_t2", 1'b0, 8'h00, 8'h41, 1'b0);
    step();
    chk_cyc("j_redir_t3", 1'b1, 8'h40, 8'h42, 1'b0);
    chk("j_redir_jump", 32'(out_is_jump), 32'd0);

    // Test 6: reset while in JWAIT with a non-empty queue.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk_cyc("r6_rst", 1'b0, 8'h00, 8'h00, 1'b0);
    step();
    step();
    chk_cyc("r6_t2", 1'b1, 8'h00, 8'h02, 1'b0);
    step();
    chk_cyc("r6_t3", 1'b1, 8'h01, 8'h03, 1'b0);
    step();
    out_ready = 1'b0;
    step();
    chk_cyc("r6_jwait", 1'b1, 8'h02, 8'h04, 1'b1);
    rst_n = 1'b0;
    step();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    chk_cyc("r6_reset", 1'b0, 8'h00, 8'h00, 1'b0);
    step();
    chk_cyc("r6_re_t1", 1'b0, 8'h00, 8'h01, 1'b0);
    step();
    chk_cyc("r6_re_t2", 1'b1, 8'h00, 8'h02, 1'b0);
    step();
    chk_cyc("r6_re_t3", 1'b1, 8'h01, 8'h03, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
